// File: rtl/fpu_addsub_param_if.sv
// fpu_addsub_param_if: request/result bundle between the CPU and the
// floating-point add/subtract unit.
//
// Signals (W = 1 + EXP_W + MAN_W):
//   start  request strobe, taken only while ready = 1
//   op     0 = A + B, 1 = A - B
//   A, B   operands, IEEE-754-style layout {sign, exponent, fraction}
//   ready  unit idle and able to accept start
//   done   one-cycle pulse, C/flags valid (and held until the next done)
//   C      result
//   flags  {invalid, overflow, underflow, inexact, zero}
//
// Modports: master = requester (CPU side), slave = the arithmetic unit.
interface fpu_addsub_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         done;
  logic [W-1:0] C;
  logic [4:0]   flags;

  modport master (
    output start, op, A, B,
    input  ready, done, C, flags
  );

  modport slave (
    input  start, op, A, B,
    output ready, done, C, flags
  );
endinterface

// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param: multi-cycle floating-point add/subtract with
// parametrised exponent/fraction widths, round-to-nearest-even,
// flush-to-zero of subnormal inputs, zero/inf/NaN handling and status flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (aborts any operation)
//   bus        fpu_addsub_param_if.slave (start/op/A/B in, ready/done/C/flags out)
//   dbg_state  current FSM state encoding (IDLE=0 .. PACK=6)
//
// Pipeline of states, one cycle each:
//   IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> PACK -> IDLE
// done pulses (with ready back at 1) in the cycle after PACK.
module fpu_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  fpu_addsub_param_if.slave  bus,
  output logic [2:0]         dbg_state
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;             // {1.frac, G, R, S}
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = EXP_W + LZW + 2;       // working exponent, two's complement
  localparam logic [EXP_W-1:0] EXP_MAX   = {EXP_W{1'b1}};
  localparam logic [XW-1:0]    EXP_TOP_X = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
  } state_t;

  state_t state;
  assign dbg_state = state;

  // Captured request
  logic [W-1:0] a_r, b_r;
  logic         op_r;
  // UNPACK results
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W:0]     ma, mb;
  logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  // ALIGN results
  logic               res_s, eff_sub;
  logic [EXP_W-1:0]   e_big;
  logic [SW-1:0]      sig_big, sig_small;
  // ADD result (extra bit for carry-out)
  logic [SW:0]        sum;
  // NORM results
  logic [XW-1:0]      exp_n;
  logic [SW-1:0]      sig_n;
  logic               cancel;
  // ROUND results
  logic [XW-1:0]      exp_r;
  logic [MAN_W-1:0]   frac_r;
  logic               inexact_r;

  // ---------------- UNPACK field decode ----------------
  logic [EXP_W-1:0] ua_e, ub_e;
  logic [MAN_W-1:0] ua_f, ub_f;
  assign ua_e = a_r[W-2 -: EXP_W];
  assign ub_e = b_r[W-2 -: EXP_W];
  assign ua_f = a_r[MAN_W-1:0];
  assign ub_f = b_r[MAN_W-1:0];

  // ---------------- ALIGN: order by magnitude, shift the smaller ----------------
  logic               a_ge_b, big_s;
  logic [EXP_W-1:0]   big_e, sml_e, shamt;
  logic [MAN_W:0]     big_m, sml_m;
  logic [SW-1:0]      sml_ext, sml_shift;
  logic               sml_lost;

  always_comb begin
    a_ge_b    = {ea, ma} >= {eb, mb};
    big_s     = a_ge_b ? sa : sb;
    big_e     = a_ge_b ? ea : eb;
    sml_e     = a_ge_b ? eb : ea;
    big_m     = a_ge_b ? ma : mb;
    sml_m     = a_ge_b ? mb : ma;
    shamt     = big_e - sml_e;
    sml_ext   = {sml_m, 3'b000};
    sml_shift = sml_ext >> shamt;
    // Everything pushed below the S position collapses into sticky; very large
    // shifts leave the whole significand in sticky.
    sml_lost  = |(sml_ext & ~({SW{1'b1}} << shamt));
  end

  // ---------------- NORM: leading-zero count ----------------
  logic [LZW-1:0] lzc;
  logic [SW-1:0]  norm_shift;

  always_comb begin
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lzc = LZW'(SW - 1 - i);
    end
    norm_shift = sum[SW-1:0] << lzc;
  end

  // ---------------- ROUND: nearest-even on G/R/S ----------------
  logic           rnd_up;
  logic [MAN_W+1:0] mant_rnd;

  always_comb begin
    rnd_up   = sig_n[2] & (sig_n[1] | sig_n[0] | sig_n[3]);
    mant_rnd = {1'b0, sig_n[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
  end

  // ---------------- PACK: specials, range checks, final assembly ----------------
  logic [W-1:0] c_nx;
  logic [4:0]   f_nx;   // {invalid, overflow, underflow, inexact, zero}
  logic         inf_clash;

  always_comb begin
    c_nx      = '0;
    f_nx      = '0;
    inf_clash = inf_a & inf_b & (sa != sb);
    if (nan_a | nan_b | inf_clash) begin
      c_nx    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
      f_nx[4] = inf_clash;
    end else if (inf_a) begin
      c_nx = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      c_nx = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end else if (zero_a & zero_b) begin
      // Only (-0)+(-0) keeps the minus sign.
      c_nx    = {sa & sb, {(W-1){1'b0}}};
      f_nx[0] = 1'b1;
    end else if (cancel) begin
      c_nx    = '0;
      f_nx[0] = 1'b1;
    end else if (!exp_r[XW-1] && (exp_r >= EXP_TOP_X)) begin
      c_nx    = {res_s, EXP_MAX, {MAN_W{1'b0}}};
      f_nx[3] = 1'b1;
      f_nx[1] = 1'b1;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      c_nx    = {res_s, {(W-1){1'b0}}};
      f_nx[2] = 1'b1;
      f_nx[1] = 1'b1;
      f_nx[0] = 1'b1;
    end else begin
      c_nx    = {res_s, exp_r[EXP_W-1:0], frac_r};
      f_nx[1] = inexact_r;
    end
  end

  // ---------------- Control FSM and registered outputs ----------------
  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // ready drops to 0 the next cycle, start is ignored while ready=0, and
  // done pulses for one cycle with ready=1 again, so a start presented in the
  // done cycle is taken immediately. C/flags hold until the next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
      bus.C     <= '0;
      bus.flags <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_UNPACK;
            bus.ready <= 1'b0;
          end
        end
        S_UNPACK: state <= S_ALIGN;
        S_ALIGN:  state <= S_ADD;
        S_ADD:    state <= S_NORM;
        S_NORM:   state <= S_ROUND;
        S_ROUND:  state <= S_PACK;
        S_PACK: begin
          state     <= S_IDLE;
          bus.ready <= 1'b1;
          bus.done  <= 1'b1;
          bus.C     <= c_nx;
          bus.flags <= f_nx;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      ma        <= '0;
      mb        <= '0;
      zero_a    <= 1'b0;
      zero_b    <= 1'b0;
      inf_a     <= 1'b0;
      inf_b     <= 1'b0;
      nan_a     <= 1'b0;
      nan_b     <= 1'b0;
      res_s     <= 1'b0;
      eff_sub   <= 1'b0;
      e_big     <= '0;
      sig_big   <= '0;
      sig_small <= '0;
      sum       <= '0;
      exp_n     <= '0;
      sig_n     <= '0;
      cancel    <= 1'b0;
      exp_r     <= '0;
      frac_r    <= '0;
      inexact_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_r  <= bus.A;
            b_r  <= bus.B;
            op_r <= bus.op;
          end
        end
        S_UNPACK: begin
          sa     <= a_r[W-1];
          sb     <= b_r[W-1] ^ op_r;      // subtraction = add with B negated
          ea     <= ua_e;
          eb     <= ub_e;
          // exp=0 (zero or subnormal) is flushed: significand forced to 0.
          ma     <= (ua_e == '0) ? '0 : {1'b1, ua_f};
          mb     <= (ub_e == '0) ? '0 : {1'b1, ub_f};
          zero_a <= (ua_e == '0);
          zero_b <= (ub_e == '0);
          inf_a  <= (ua_e == EXP_MAX) && (ua_f == '0);
          inf_b  <= (ub_e == EXP_MAX) && (ub_f == '0);
          nan_a  <= (ua_e == EXP_MAX) && (ua_f != '0);
          nan_b  <= (ub_e == EXP_MAX) && (ub_f != '0);
        end
        S_ALIGN: begin
          res_s     <= big_s;
          eff_sub   <= sa ^ sb;
          e_big     <= big_e;
          sig_big   <= {big_m, 3'b000};
          sig_small <= sml_shift | SW'(sml_lost);
        end
        S_ADD: begin
          // The larger magnitude is first, so the difference never goes negative.
          sum <= eff_sub ? ({1'b0, sig_big} - {1'b0, sig_small})
                         : ({1'b0, sig_big} + {1'b0, sig_small});
        end
        S_NORM: begin
          cancel <= (sum == '0);
          if (sum[SW]) begin
            sig_n <= {sum[SW:2], sum[1] | sum[0]};
            exp_n <= XW'(e_big) + XW'(1);
          end else begin
            sig_n <= norm_shift;
            exp_n <= XW'(e_big) - XW'(lzc);
          end
        end
        S_ROUND: begin
          inexact_r <= sig_n[2] | sig_n[1] | sig_n[0];
          if (mant_rnd[MAN_W+1]) begin
            frac_r <= mant_rnd[MAN_W:1];
            exp_r  <= exp_n + XW'(1);
          end else begin
            frac_r <= mant_rnd[MAN_W-1:0];
            exp_r  <= exp_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
